// File: rtl/wavegen_pkg.sv
// Shared definitions for the wavegen sine path: widths, channel tag,
// quadrant folding and the quarter-wave table generator.
package wavegen_pkg;

  localparam int PHASE_W   = 12;
  localparam int SAMPLE_W  = 16;
  localparam int QTR_DEPTH = 1024;
  localparam int ADDR_W    = PHASE_W - 2;
  localparam int MAG_W     = SAMPLE_W - 1;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_t;

  typedef struct packed {
    logic [ADDR_W-1:0] fold;
    logic              negate;
  } quad_t;

  // Quadrants 1 and 3 read the table backwards (1023-i == ~i).
  // Quadrants 2 and 3 negate the sample.
  function automatic quad_t quad_decode(input logic [PHASE_W-1:0] phase);
    quad_t d;
    d.fold   = phase[PHASE_W-2] ? ~phase[ADDR_W-1:0] : phase[ADDR_W-1:0];
    d.negate = phase[PHASE_W-1];
    return d;
  endfunction

  // Table entry k = round(32767*sin(2*pi*(k+0.5)/(4*QTR_DEPTH))).
  // The half-step offset makes the mirrored quadrants exact.
  // Every entry is positive, so adding 0.5 before truncating rounds correctly.
  function automatic logic [MAG_W-1:0] quarter_sample(input int k);
    real ang;
    real mag;
    ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / (4.0 * real'(QTR_DEPTH));
    mag = 32767.0 * $sin(ang);
    return MAG_W'($rtoi(mag + 0.5));
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Single-port quarter-wave sine ROM with a registered output.
// The output register is the S2 data stage of the lookup pipeline.
module sine_quarter_rom
  import wavegen_pkg::*;
#(
  parameter int DEPTH  = QTR_DEPTH,
  parameter int AW     = ADDR_W,
  parameter int DW     = MAG_W
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic [DW-1:0] rom_table [DEPTH];
  logic [DW-1:0] data_reg;

  // The table is a pure constant per entry, so synthesis folds it into ROM contents.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom_table[gi] = quarter_sample(gi);
  end

  // Registered read so the table maps onto a block RAM output register.
  always_ff @(posedge clk) begin
    data_reg <= rom_table[addr];
  end

  assign data = data_reg;

endmodule

// File: rtl/sine_lut_server.sv
// Two-channel sine sample server sharing one quarter-wave ROM.
// Channels A and B take alternating capture slots; three stages:
// S1 capture/fold, S2 ROM read, S3 negate and write-back.
module sine_lut_server
  import wavegen_pkg::*;
#(
  parameter int PHASE_W   = 12,
  parameter int SAMPLE_W  = 16,
  parameter int QTR_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PHASE_W-1:0]  phase_A,
  input  logic [PHASE_W-1:0]  phase_B,
  output logic [SAMPLE_W-1:0] sine_A,
  output logic [SAMPLE_W-1:0] sine_B,
  output logic                valid_A,
  output logic                valid_B
);

  localparam int AW = PHASE_W - 2;
  localparam int DW = SAMPLE_W - 1;

  chan_t                slot_reg, slot_next;
  logic                 s1_valid_reg;
  chan_t                s1_chan_reg;
  logic                 s1_neg_reg;
  logic [AW-1:0]        s1_addr_reg;
  logic                 s2_valid_reg;
  chan_t                s2_chan_reg;
  logic                 s2_neg_reg;
  logic [DW-1:0]        rom_data;
  logic [SAMPLE_W-1:0]  sine_a_reg, sine_b_reg;
  logic                 valid_a_reg, valid_b_reg;
  logic [PHASE_W-1:0]   phase_sel;
  quad_t                dec_next;
  logic [SAMPLE_W-1:0]  mag_ext;
  logic [SAMPLE_W-1:0]  result_next;

  // Slot register: flips only on edges that capture, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_reg <= CH_A;
    else        slot_reg <= slot_next;
  end

  // Next slot, current channel selection and quadrant fold.
  always_comb begin
    slot_next = slot_reg;
    if (en) slot_next = (slot_reg == CH_A) ? CH_B : CH_A;
    phase_sel = (slot_reg == CH_A) ? phase_A : phase_B;
    dec_next  = quad_decode(phase_sel);
  end

  // S1: capture channel, negate flag and folded address when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_chan_reg  <= CH_A;
      s1_neg_reg   <= 1'b0;
      s1_addr_reg  <= '0;
    end else begin
      s1_valid_reg <= en;
      if (en) begin
        s1_chan_reg <= slot_reg;
        s1_neg_reg  <= dec_next.negate;
        s1_addr_reg <= dec_next.fold;
      end
    end
  end

  sine_quarter_rom #(
    .DEPTH (QTR_DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_rom (
    .clk  (clk),
    .addr (s1_addr_reg),
    .data (rom_data)
  );

  // S2 side-band: tag the ROM read data with its channel and sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_chan_reg  <= CH_A;
      s2_neg_reg   <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_chan_reg  <= s1_chan_reg;
      s2_neg_reg   <= s1_neg_reg;
    end
  end

  // Conditional negate; magnitude never exceeds 32767 so it cannot overflow.
  always_comb begin
    mag_ext     = {1'b0, rom_data};
    result_next = s2_neg_reg ? (~mag_ext + 1'b1) : mag_ext;
  end

  // S3: update only the addressed channel and pulse its valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sine_a_reg  <= '0;
      sine_b_reg  <= '0;
      valid_a_reg <= 1'b0;
      valid_b_reg <= 1'b0;
    end else begin
      valid_a_reg <= s2_valid_reg && (s2_chan_reg == CH_A);
      valid_b_reg <= s2_valid_reg && (s2_chan_reg == CH_B);
      if (s2_valid_reg && (s2_chan_reg == CH_A)) sine_a_reg <= result_next;
      if (s2_valid_reg && (s2_chan_reg == CH_B)) sine_b_reg <= result_next;
    end
  end

  assign sine_A  = sine_a_reg;
  assign sine_B  = sine_b_reg;
  assign valid_A = valid_a_reg;
  assign valid_B = valid_b_reg;

endmodule

// File: tb/tb_sine_lut_server.sv
// Self-checking bench for sine_lut_server: full-wave reference model,
// randomized phases and enable, directed quadrant/latency/reset/sweep cases.
module tb_sine_lut_server;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] phase_A, phase_B;
  logic [15:0] sine_A, sine_B;
  logic        valid_A, valid_B;

  int checks;
  int errors;

  typedef struct {
    bit          ch;     // 0 = A, 1 = B
    logic [15:0] val;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          edge_cnt;
  bit          next_ch;
  logic [15:0] exp_sine_a, exp_sine_b;
  logic        exp_va, exp_vb;
  int          pulse_cnt;

  sine_lut_server dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .phase_A (phase_A),
    .phase_B (phase_B),
    .sine_A  (sine_A),
    .sine_B  (sine_B),
    .valid_A (valid_A),
    .valid_B (valid_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at edge %0d", tag, obs, exp, edge_cnt);
    end
  endtask

  // Full-wave reference: round(32767*sin(2*pi*(phase+0.5)/4096)), symmetric rounding.
  function automatic logic [15:0] ref_sine(input logic [11:0] ph);
    real v;
    int  r;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(ph) + 0.5) / 4096.0);
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(-v + 0.5);
    return 16'(r);
  endfunction

  function automatic void model_reset();
    pend.delete();
    next_ch    = 1'b0;
    exp_sine_a = '0;
    exp_sine_b = '0;
    exp_va     = 1'b0;
    exp_vb     = 1'b0;
  endfunction

  // One clock: drive at negedge, update model at posedge, compare 1 time unit later.
  task automatic step(input logic en_v, input logic [11:0] pa, input logic [11:0] pb);
    pend_t p;
    en = en_v; phase_A = pa; phase_B = pb;
    @(posedge clk);
    edge_cnt++;
    exp_va = 1'b0;
    exp_vb = 1'b0;
    if (rst_n) begin
      while (pend.size() > 0 && pend[0].due == edge_cnt) begin
        p = pend.pop_front();
        if (p.ch == 1'b0) begin exp_sine_a = p.val; exp_va = 1'b1; end
        else              begin exp_sine_b = p.val; exp_vb = 1'b1; end
      end
      if (en_v) begin
        p.ch  = next_ch;
        p.val = ref_sine(next_ch ? pb : pa);
        p.due = edge_cnt + 2;
        pend.push_back(p);
        next_ch = ~next_ch;
      end
    end
    #1;
    check_eq("valid_A", {15'd0, valid_A}, {15'd0, exp_va});
    check_eq("valid_B", {15'd0, valid_B}, {15'd0, exp_vb});
    check_eq("sine_A", sine_A, exp_sine_a);
    check_eq("sine_B", sine_B, exp_sine_b);
    if (valid_A) $display("txn A sine=%h edge=%0d", sine_A, edge_cnt);
    if (valid_B) $display("txn B sine=%h edge=%0d", sine_B, edge_cnt);
    pulse_cnt += int'(valid_A) + int'(valid_B);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [11:0] qph [5];
  logic [15:0] qexp[5];
  logic [11:0] ph;

  initial begin
    checks = 0; errors = 0; edge_cnt = 0; pulse_cnt = 0;
    en = 1'b0; phase_A = '0; phase_B = '0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_sine_A", sine_A, 16'h0000);
    check_eq("rst_sine_B", sine_B, 16'h0000);
    check_eq("rst_valid", {14'd0, valid_A, valid_B}, 16'h0000);
    rst_n = 1'b1;

    // Quadrant values on channel A
    qph[0] = 12'h000; qexp[0] = 16'h0019;
    qph[1] = 12'h3FF; qexp[1] = 16'h7FFF;
    qph[2] = 12'h400; qexp[2] = 16'h7FFF;
    qph[3] = 12'h800; qexp[3] = 16'hFFE7;
    qph[4] = 12'hC00; qexp[4] = 16'h8001;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) step(1'b1, qph[i], 12'($urandom));
      check_eq("quadrant", sine_A, qexp[i]);
    end

    // Latency and interleave from a clean reset
    do_reset();
    step(1'b1, 12'h000, 12'h800);
    step(1'b1, 12'h000, 12'h800);
    step(1'b1, 12'h000, 12'h800);
    check_eq("lat_valid_A", {15'd0, valid_A}, 16'd1);
    check_eq("lat_sine_A", sine_A, 16'd25);
    step(1'b1, 12'h000, 12'h800);
    check_eq("lat_valid_B", {15'd0, valid_B}, 16'd1);
    check_eq("lat_sine_B", sine_B, 16'hFFE7);
    step(1'b1, 12'h000, 12'h800);
    check_eq("alt_valid_A", {15'd0, valid_A}, 16'd1);

    // en drop after an A capture followed by its B capture
    while (next_ch != 1'b1) step(1'b1, 12'($urandom), 12'($urandom));
    step(1'b1, 12'($urandom), 12'($urandom));
    pulse_cnt = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 12'($urandom), 12'($urandom));
    check_eq("drain_pulses", 16'(pulse_cnt), 16'd2);

    // Randomized enable and phases; en resumes from the held slot
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 8), 12'($urandom), 12'($urandom));

    // Asynchronous reset with lookups in flight
    step(1'b1, 12'($urandom), 12'($urandom));
    step(1'b1, 12'($urandom), 12'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_sine_A", sine_A, 16'h0000);
    check_eq("mid_rst_sine_B", sine_B, 16'h0000);
    check_eq("mid_rst_valid", {14'd0, valid_A, valid_B}, 16'h0000);
    @(negedge clk);
    step(1'b0, 12'($urandom), 12'($urandom));
    rst_n = 1'b1;
    pulse_cnt = 0;
    step(1'b0, 12'($urandom), 12'($urandom));
    step(1'b0, 12'($urandom), 12'($urandom));
    check_eq("post_rst_pulses", 16'(pulse_cnt), 16'd0);

    // Full sweep on channel A, two cycles per phase
    do_reset();
    for (int p = 0; p < 4096; p++) begin
      ph = 12'(p);
      step(1'b1, ph, 12'($urandom));
      step(1'b1, ph, 12'($urandom));
    end
    step(1'b1, 12'h000, 12'($urandom));
    check_eq("wrap_FFF", sine_A, 16'hFFE7);
    step(1'b1, 12'h000, 12'($urandom));
    step(1'b1, 12'h000, 12'($urandom));
    check_eq("wrap_000", sine_A, 16'h0019);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
